// File: rtl/compare_sequencer_pkg.sv
// Shared constants for the compare sequencer: state encoding, mode codes, default width.
package compare_pkg;

    localparam int WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    localparam logic MODE_EQ = 1'b0;
    localparam logic MODE_NE = 1'b1;

endpackage

// File: rtl/compare_sequencer_if.sv
// Upstream, logic-unit and downstream signal bundle for the compare sequencer.
interface compare_sequencer_if
    import compare_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sel;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_sel;
    logic             cmp_result;
    logic             out_valid;
    logic             out_ready;
    logic             out_result;
    logic             out_sel;

    // slave: the sequencer's view; master: upstream, downstream and logic unit combined
    modport slave (
        input  in_valid, in_a, in_b, in_sel, cmp_result, out_ready,
        output in_ready, cmp_a, cmp_b, cmp_sel, out_valid, out_result, out_sel
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, cmp_result, out_ready,
        input  in_ready, cmp_a, cmp_b, cmp_sel, out_valid, out_result, out_sel
    );

endinterface

// File: rtl/compare_sequencer_sat_counter.sv
// Saturating up-counter; clear takes priority over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/compare_sequencer.sv
// Registers an operand pair into the external compare unit, waits one settling
// cycle, then holds the sampled result downstream until it is taken.
module compare_sequencer
    import compare_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    compare_sequencer_if.slave  bus,
    input  logic                clear_count,
    output logic [CNT_W-1:0]    true_count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cmp_a_q, cmp_b_q;
    logic             cmp_sel_q;
    logic             out_result_q, out_sel_q;
    logic             accept, sample;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_DRIVE;
            S_DRIVE: state_d = S_HOLD;
            S_HOLD:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // operands only move on an accepted transfer, so idle X on in_* never lands
    assign accept = (state_q == S_IDLE) && bus.in_valid;
    assign sample = (state_q == S_DRIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_a_q   <= '0;
            cmp_b_q   <= '0;
            cmp_sel_q <= MODE_EQ;
        end else if (accept) begin
            cmp_a_q   <= bus.in_a;
            cmp_b_q   <= bus.in_b;
            cmp_sel_q <= bus.in_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result_q <= 1'b0;
            out_sel_q    <= MODE_EQ;
        end else if (sample) begin
            out_result_q <= bus.cmp_result;
            out_sel_q    <= cmp_sel_q;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (sample && bus.cmp_result),
        .clr_i (clear_count),
        .cnt_o (true_count)
    );

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_HOLD);
    assign bus.cmp_a      = cmp_a_q;
    assign bus.cmp_b      = cmp_b_q;
    assign bus.cmp_sel    = cmp_sel_q;
    assign bus.out_result = out_result_q;
    assign bus.out_sel    = out_sel_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Directed bench for compare_sequencer with a behavioural 6-bit compare unit.
module tb_compare_sequencer;
    import compare_pkg::*;

    localparam int W  = 6;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_count = 1'b0;
    logic [CW-1:0] true_count;
    int            err_cnt = 0;
    int            chk_cnt = 0;
    int            exp_cnt = 0;

    always #5 clk = ~clk;

    compare_sequencer_if #(.WIDTH(W)) bus();

    assign bus.cmp_result = (bus.cmp_sel == MODE_NE) ? (bus.cmp_a != bus.cmp_b)
                                                     : (bus.cmp_a == bus.cmp_b);

    compare_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .clear_count (clear_count),
        .true_count  (true_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where HOLD is visible.
    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic exp_r, input logic clr, input string tag);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sel = s;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_a = 'x; bus.in_b = 'x; bus.in_sel = 1'bx;
        chk({tag, "_drv_rdy"}, bus.in_ready, 0);
        chk({tag, "_drv_vld"}, bus.out_valid, 0);
        chk({tag, "_cmp_a"}, bus.cmp_a, a);
        chk({tag, "_cmp_b"}, bus.cmp_b, b);
        clear_count = clr;
        @(negedge clk);
        clear_count = 1'b0;
        if (clr) exp_cnt = 0;
        else if (exp_r && exp_cnt < 3) exp_cnt++;
        chk({tag, "_vld"}, bus.out_valid, 1);
        chk({tag, "_res"}, bus.out_result, exp_r);
        chk({tag, "_sel"}, bus.out_sel, s);
        chk({tag, "_cnt"}, true_count, exp_cnt);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        chk({tag, "_idle_rdy"}, bus.in_ready, 1);
        chk({tag, "_idle_vld"}, bus.out_valid, 0);
    endtask

    logic [W-1:0] va [4] = '{6'd3, 6'd3, 6'd7, 6'd8};
    logic [W-1:0] vb [4] = '{6'd3, 6'd4, 6'd7, 6'd1};
    logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic         vr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc [8];
        logic res [8];
        int nacc, nx, idx;
        bit adv;

        bus.in_valid = 1'b0; bus.in_a = 'x; bus.in_b = 'x; bus.in_sel = 1'bx;
        bus.out_ready = 1'b1;

        // reset state
        #12;
        chk("rst_rdy", bus.in_ready, 1);
        chk("rst_vld", bus.out_valid, 0);
        chk("rst_cmp_a", bus.cmp_a, 0);
        chk("rst_cmp_sel", bus.cmp_sel, 0);
        chk("rst_res", bus.out_result, 0);
        chk("rst_cnt", true_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmp_b", bus.cmp_b, 0);

        // single equal, then inequality mode
        txn(6'b000101, 6'b000101, 1'b0, 1'b1, 1'b0, "eq1");
        release_out("eq1");
        txn(6'b001010, 6'b000101, 1'b1, 1'b1, 1'b0, "ne1");
        release_out("ne1");
        txn(6'b001010, 6'b001010, 1'b1, 1'b0, 1'b0, "ne0");
        release_out("ne0");
        chk("idle_cmp_hold", bus.cmp_a, 6'b001010);

        // backpressure with ignored in_valid pulses
        bus.out_ready = 1'b0;
        txn(6'd17, 6'd17, 1'b0, 1'b1, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~i[0]; bus.in_a = 6'h3f; bus.in_b = 6'h00; bus.in_sel = 1'b1;
            @(negedge clk);
            chk("bp_vld", bus.out_valid, 1);
            chk("bp_res", bus.out_result, 1);
            chk("bp_rdy", bus.in_ready, 0);
            chk("bp_cmp_a", bus.cmp_a, 6'd17);
        end
        bus.in_valid = 1'b0; bus.in_a = 'x; bus.in_b = 'x; bus.in_sel = 1'bx;
        bus.out_ready = 1'b1;
        release_out("bp");

        // saturation and clear
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        exp_cnt = 0;
        chk("clr_idle", true_count, 0);
        for (int i = 0; i < 5; i++) begin
            txn(6'(i), 6'(i + 1), 1'b1, 1'b1, 1'b0, "sat");
            release_out("sat");
        end
        chk("sat_top", true_count, 3);
        txn(6'd9, 6'd9, 1'b0, 1'b1, 1'b1, "clr_inc");
        release_out("clr_inc");

        // asynchronous reset while holding a result
        bus.out_ready = 1'b0;
        txn(6'd21, 6'd42, 1'b1, 1'b1, 1'b0, "mid");
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("mid_vld", bus.out_valid, 0);
        chk("mid_cmp_a", bus.cmp_a, 0);
        chk("mid_cmp_b", bus.cmp_b, 0);
        chk("mid_rdy", bus.in_ready, 1);
        chk("mid_cnt", true_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_stale", bus.out_valid, 0);
        end

        // back-to-back stream
        nacc = 0; nx = 0; idx = 0; adv = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = va[0]; bus.in_b = vb[0]; bus.in_sel = vs[0];
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus.in_valid && bus.in_ready) begin
                if (nacc < 8) acc_cyc[nacc] = cyc;
                nacc++;
                adv = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (nx < 8) res[nx] = bus.out_result;
                nx++;
            end
            @(negedge clk);
            if (adv) begin
                adv = 1'b0;
                idx++;
                if (idx < 4) begin
                    bus.in_a = va[idx]; bus.in_b = vb[idx]; bus.in_sel = vs[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        chk("b2b_acc", nacc, 4);
        chk("b2b_xfer", nx, 4);
        for (int k = 1; k < 4; k++)
            if (k < nacc) chk("b2b_space", acc_cyc[k] - acc_cyc[k-1], 3);
        for (int k = 0; k < 4; k++)
            if (k < nx) chk("b2b_res", res[k], vr[k]);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
